// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the UART transmit-path arbiter family.
//   arb_state_t   : packet-level arbiter state (IDLE / BUSY)
//   NREQ_DEFAULT  : default number of byte-stream requesters
//   DW_DEFAULT    : default byte width on the tx FIFO path
// ---------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int DW_DEFAULT   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage : uart_arb_pkg

// File: rtl/rr_arb_pick.sv
// ---------------------------------------------------------------------------
// rr_arb_pick
// Combinational round-robin picker. Searches the request vector upward
// from the pointer position, wrapping at N, and returns the first set bit
// as a one-hot vector.
// Ports:
//   i_req  [N-1:0]    request vector
//   i_ptr  [PTRW-1:0] search start index (0..N-1)
//   o_pick [N-1:0]    one-hot winner, all-zero when no request
//   o_any             at least one request present
// ---------------------------------------------------------------------------
module rr_arb_pick
  import uart_arb_pkg::*;
#(
  parameter int N    = NREQ_DEFAULT,
  parameter int PTRW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [N-1:0]    o_pick,
  output logic            o_any
);

  always_comb begin
    logic            w_found;
    logic [PTRW-1:0] w_idx;
    int              w_sum;
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = 0;
    for (int i = 0; i < N; i++) begin
      // Candidate index (ptr + i) mod N without a divider.
      w_sum = int'(i_ptr) + i;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = PTRW'(w_sum);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule : rr_arb_pick

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the single UART tx FIFO write port between NREQ byte-stream
// producers. Round-robin at packet granularity: the grant is held from the
// first byte until the byte flagged last, so packets never interleave.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN): an owner that leaves valid
// low for TIMEOUT_CYCLES BUSY cycles loses the grant and timeout_err pulses.
// Without the macro the grant is held indefinitely and timeout_err is 0.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid [NREQ]    per-requester byte valid
//   req_data  [NREQ*DW] requester i at [i*DW +: DW]
//   req_last  [NREQ]    final byte of a packet
//   req_ready [NREQ]    per-requester accept (only the owner, when not full)
//   tfifo_full          tx FIFO full
//   tfifo_wr            tx FIFO write strobe
//   tfifo_din [DW]      tx FIFO write data
//   grant     [NREQ]    one-hot current owner, zero when idle
//   busy                a packet is in progress
//   timeout_err         one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ           = NREQ_DEFAULT,
  parameter int DW             = DW_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tfifo_full,
  output logic                 tfifo_wr,
  output logic [DW-1:0]        tfifo_din,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int PTRW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t      r_state;
  logic [NREQ-1:0] r_grant;
  logic [PTRW-1:0] r_ptr;
  logic            r_busy;

  logic [NREQ-1:0] w_pick;
  logic            w_any;
  logic [PTRW-1:0] w_owner;
  logic [PTRW-1:0] w_next_ptr;
  logic [DW-1:0]   w_din;
  logic            w_owner_last;
  logic            w_xfer;

  rr_arb_pick #(
    .N    (NREQ),
    .PTRW (PTRW)
  ) u_pick (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  // Owner index and its data byte, decoded from the registered one-hot grant.
  always_comb begin
    w_owner = '0;
    w_din   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_owner = PTRW'(i);
        w_din   = req_data[i*DW +: DW];
      end
    end
  end

  assign w_next_ptr   = (w_owner == PTRW'(NREQ - 1)) ? '0 : w_owner + PTRW'(1);
  assign w_owner_last = |(req_last & r_grant);

  // Ready is gated by full, so a write can never be issued into a full FIFO.
  assign req_ready = r_grant & {NREQ{~tfifo_full}};
  assign w_xfer    = |(req_valid & req_ready);
  assign tfifo_wr  = w_xfer;
  assign tfifo_din = w_xfer ? w_din : '0;
  assign grant     = r_grant;
  assign busy      = r_busy;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;
  logic          w_owner_valid;

  assign w_owner_valid = |(req_valid & r_grant);
  assign timeout_err   = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= BUSY;
            r_grant <= w_pick;
            r_busy  <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          if (w_xfer && w_owner_last) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= w_next_ptr;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (w_xfer) begin
            r_cnt <= '0;
          end else if (!w_owner_valid) begin
            // Only owner-idle cycles count; full-only stalls are not the
            // requester's fault.
            if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              r_state       <= IDLE;
              r_grant       <= '0;
              r_busy        <= 1'b0;
              r_ptr         <= w_next_ptr;
              r_timeout_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (NREQ=4, DW=8, TIMEOUT_CYCLES=16).
// Requesters are modelled as byte queues; a packet-level reference model
// predicts the owner, accepts and FIFO writes every cycle.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic                tfifo_full;
  logic                tfifo_wr;
  logic [DW-1:0]       tfifo_din;
  logic [NREQ-1:0]     grant;
  logic                busy;
  logic                timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ           (NREQ),
    .DW             (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tfifo_full  (tfifo_full),
    .tfifo_wr    (tfifo_wr),
    .tfifo_din   (tfifo_din),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  // Requester side: pending bytes per requester and handshake bookkeeping.
  logic [DW-1:0] q_data[NREQ][$];
  bit            q_last[NREQ][$];
  bit            hold[NREQ];
  bit            alt[NREQ];
  bit            acc[NREQ];
  int            gap[NREQ];   // 0 always valid, 1 every other cycle, 2 random

  // Reference model: owner (-1 idle), rr pointer, owner stall count.
  int m_owner;
  int m_ptr;
  int m_cnt;
  bit m_terr;

  // Observed FIFO stream.
  logic [DW-1:0] got_byte[$];
  int            got_src[$];
  int            got_cyc[$];
  int            terr_cyc[$];
  int            cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_first(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic push(input int r, input logic [DW-1:0] b, input bit l);
    q_data[r].push_back(b);
    q_last[r].push_back(l);
  endtask

  task automatic clear_got();
    got_byte.delete();
    got_src.delete();
    got_cyc.delete();
    terr_cyc.delete();
  endtask

  // Requester behaviour: once valid is raised, data/last/valid stay put
  // until accepted.
  task automatic drive();
    bit v;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
        hold[i] = 1'b0;
        acc[i]  = 1'b0;
      end
      if (!hold[i]) begin
        v = 1'b0;
        if (q_data[i].size() > 0) begin
          case (gap[i])
            0:       v = 1'b1;
            1:       v = !alt[i];
            default: v = ($urandom_range(0, 3) != 0);
          endcase
        end
        alt[i]  = v;
        hold[i] = v;
        req_valid[i] = v;
        req_data[i*DW +: DW] = v ? q_data[i][0] : DW'($urandom);
        req_last[i]  = v ? q_last[i][0] : 1'($urandom);
      end
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, drive at +1.
  task automatic cycle();
    logic [NREQ-1:0] e_grant, e_ready, s_valid, s_last;
    logic            e_wr, s_full, s_rst;
    logic [DW-1:0]   e_din;
    int              w;
    @(negedge clk);
    cyc++;
    e_grant = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    e_ready = tfifo_full ? '0 : e_grant;
    e_wr    = (m_owner >= 0) && req_valid[m_owner] && !tfifo_full;
    e_din   = '0;
    if (e_wr && q_data[m_owner].size() > 0) e_din = q_data[m_owner][0];
    check("grant", grant, e_grant);
    check("req_ready", req_ready, e_ready);
    check("tfifo_wr", tfifo_wr, e_wr);
    check("tfifo_din", tfifo_din, e_din);
    check("busy", busy, m_owner >= 0);
    check("timeout_err", timeout_err, m_terr);
    if (tfifo_wr) begin
      got_byte.push_back(tfifo_din);
      got_src.push_back(m_owner);
      got_cyc.push_back(cyc);
    end
    if (timeout_err) terr_cyc.push_back(cyc);
    for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] && req_ready[i];
    s_valid = req_valid;
    s_last  = req_last;
    s_full  = tfifo_full;
    s_rst   = rst_n;
    @(posedge clk);
    m_terr = 1'b0;
    if (!s_rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      w = rr_first(s_valid, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_cnt   = 0;
      end
    end else if (s_valid[m_owner] && !s_full) begin
      m_cnt = 0;
      if (s_last[m_owner]) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
    else if (!s_valid[m_owner]) begin
      m_cnt++;
      if (m_cnt == TO) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_terr  = 1'b1;
      end
    end
`endif
    #1;
    drive();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NREQ; i++) begin
      if (q_data[i].size() > 0 || hold[i]) return 1'b0;
    end
    return m_owner < 0;
  endfunction

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!all_idle() && n < max_cyc) begin
      cycle();
      n++;
    end
    check(tag, n < max_cyc, 1'b1);
    cycle();
    cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] exp3[8];
    int            n;
    int            base;
    int            total_sent;

    rst_n      = 1'b0;
    tfifo_full = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    m_owner    = -1;
    m_ptr      = 0;
    m_cnt      = 0;
    m_terr     = 1'b0;
    cyc        = 0;
    total_sent = 0;
    for (int i = 0; i < NREQ; i++) begin
      gap[i]  = 0;
      hold[i] = 1'b0;
      alt[i]  = 1'b0;
      acc[i]  = 1'b0;
    end

    // Reset with every requester valid, then round robin of 2-byte packets.
    for (int i = 0; i < NREQ; i++) begin
      push(i, 8'hA0 | DW'(i), 1'b0);
      push(i, 8'hB0 | DW'(i), 1'b1);
    end
    drive();
    @(posedge clk);
    #1;
    repeat (3) cycle();
    rst_n = 1'b1;
    clear_got();
    cycle();
    check("rel_grant", grant, 4'b0001);
    drain("rr_drain", 100);
    check("rr_count", got_byte.size(), 8);
    for (int k = 0; k < 8 && k < got_byte.size(); k++) begin
      check("rr_byte", got_byte[k], ((k % 2) ? 8'hB0 : 8'hA0) | DW'(k / 2));
      check("rr_spacing", got_cyc[k] - got_cyc[0], (k / 2) * 3 + (k % 2));
    end

    // Gapped "HELLO" on req0 against a continuously valid req2.
    clear_got();
    gap[0] = 1;
    push(0, "H", 1'b0);
    push(0, "E", 1'b0);
    push(0, "L", 1'b0);
    push(0, "L", 1'b0);
    push(0, "O", 1'b1);
    push(2, 8'h21, 1'b0);
    push(2, 8'h22, 1'b0);
    push(2, 8'h23, 1'b1);
    drive();
    drain("ni_drain", 100);
    exp3 = '{"H", "E", "L", "L", "O", 8'h21, 8'h22, 8'h23};
    check("ni_count", got_byte.size(), 8);
    for (int k = 0; k < 8 && k < got_byte.size(); k++) begin
      check("ni_byte", got_byte[k], exp3[k]);
    end
    gap[0] = 0;

    // Backpressure: FIFO full for 10 cycles after two bytes of req1.
    clear_got();
    for (int k = 0; k < 6; k++) push(1, 8'h10 + DW'(k), k == 5);
    drive();
    n = 0;
    while (got_byte.size() < 2 && n < 50) begin
      cycle();
      n++;
    end
    check("bp_start", n < 50, 1'b1);
    tfifo_full = 1'b1;
    base = got_byte.size();
    repeat (10) cycle();
    check("bp_no_write", got_byte.size(), base);
    check("bp_grant_held", grant, 4'b0010);
    tfifo_full = 1'b0;
    drain("bp_drain", 100);
    check("bp_count", got_byte.size(), 6);
    for (int k = 0; k < 6 && k < got_byte.size(); k++) begin
      check("bp_byte", got_byte[k], 8'h10 + DW'(k));
    end

    // Wrap: req2 packet moves the pointer to 3, then req0+req3 single bytes.
    push(2, 8'h2C, 1'b1);
    drive();
    drain("wr_drain0", 50);
    clear_got();
    push(0, 8'h0D, 1'b1);
    push(3, 8'h3D, 1'b1);
    drive();
    drain("wr_drain1", 50);
    check("wr_count", got_byte.size(), 2);
    if (got_byte.size() == 2) begin
      check("wr_first", got_byte[0], 8'h3D);
      check("wr_second", got_byte[1], 8'h0D);
      check("wr_single_cycle", got_cyc[1] - got_cyc[0], 2);
    end
    // Pointer must now be 1: req1 beats req0.
    clear_got();
    push(0, 8'h0E, 1'b1);
    push(1, 8'h1E, 1'b1);
    drive();
    drain("wr_drain2", 50);
    check("ptr_count", got_byte.size(), 2);
    if (got_byte.size() == 2) begin
      check("ptr_first", got_byte[0], 8'h1E);
      check("ptr_second", got_byte[1], 8'h0E);
    end

    // Random traffic with gaps and FIFO backpressure.
    clear_got();
    for (int i = 0; i < NREQ; i++) gap[i] = 2;
    repeat (400) begin
      cycle();
      tfifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (q_data[i].size() == 0 && !hold[i] && $urandom_range(0, 7) == 0) begin
          n = int'($urandom_range(1, 4));
          for (int k = 0; k < n; k++) push(i, DW'($urandom), k == n - 1);
          total_sent += n;
        end
      end
    end
    tfifo_full = 1'b0;
    drain("rnd_drain", 500);
    check("rnd_total", got_byte.size(), total_sent);
    for (int i = 0; i < NREQ; i++) gap[i] = 0;

`ifdef UART_ARB_TIMEOUT_EN
    // req1 sends one byte and goes silent; req3 is waiting.
    clear_got();
    push(1, 8'h51, 1'b0);
    drive();
    n = 0;
    while (got_byte.size() < 1 && n < 20) begin
      cycle();
      n++;
    end
    push(3, 8'h53, 1'b1);
    drive();
    n = 0;
    while (got_byte.size() < 2 && n < 60) begin
      cycle();
      n++;
    end
    check("to_bound", n < 60, 1'b1);
    repeat (3) cycle();
    check("to_pulses", terr_cyc.size(), 1);
    if (terr_cyc.size() == 1 && got_cyc.size() == 2) begin
      check("to_delay", terr_cyc[0] - got_cyc[0], TO + 1);
      check("to_next_src", got_src[1], 3);
      check("to_next_byte", got_byte[1], 8'h53);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO (tfifo) between several byte-stream producers: screen renderer, button/command echo, status messages.
- Arbitration is round-robin at packet granularity. A grant is held from the first byte to the byte flagged last, so messages never interleave on TxD.
- Sits between the producers and the tfifo write port inside the top level, upstream of the UART transmitter.

Parameters:
- NREQ, 4: number of requesters (2..8).
- DW, 8: byte width on the FIFO path.
- TIMEOUT_CYCLES, 1024: stall limit for the optional timeout. Only used with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*DW  packed bytes; requester i occupies [i*DW +: DW].
- req_last  in  NREQ  marks the final byte of a packet.
- req_ready  out  NREQ  per-requester accept.
- tfifo_full  in  1  tx FIFO full.
- tfifo_wr  out  1  tx FIFO write strobe.
- tfifo_din  out  DW  tx FIFO write data.
- grant  out  NREQ  one-hot current owner; all-zero when idle.
- busy  out  1  a packet is in progress.
- timeout_err  out  1  one-cycle pulse on forced release; constant 0 without the macro.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, grant=0, busy=0, rr pointer=0, timeout_err=0.
  - Because grant=0, req_ready=0, tfifo_wr=0 and tfifo_din=0.
- Reset mid-packet aborts the packet. No further bytes are written, and the requester restarts its packet after reset.
- States:
  - IDLE: if any req_valid bit is set, pick the first set index searching upward from the rr pointer (wrapping). Register grant one-hot to that index; state=BUSY; busy=1. The arbitration decision costs 1 cycle. No request means stay in IDLE.
  - BUSY, owner g:
    - req_ready[g] = !tfifo_full, combinational; all other req_ready bits are 0.
    - Transfer occurs when req_valid[g] && req_ready[g].
    - On a transfer, in the same cycle: tfifo_wr=1 and tfifo_din=req_data[g], combinational from the registered grant. This path can never write while full.
    - Transfer with req_last[g]=1: next cycle state=IDLE, grant=0, busy=0, rr pointer=(g+1) mod NREQ.
    - req_valid[g]=0 mid-packet: grant is held with no write; other requesters wait.
- Timing:
  - There is one idle bubble between consecutive packets.
  - Peak throughput is 1 byte/clk within a packet.
  - A single-byte packet (last on its first byte) takes grant + 1 write cycle.
- Requester rule: data, valid and last must stay stable while valid && !ready. The arbiter does not capture bytes.
- Simultaneous requests are resolved purely by the rr pointer. A new request that arrives during BUSY waits; it is never preempted.
- tfifo_full asserted mid-packet stalls the transfer. Deasserting it resumes the same owner.
- tfifo_wr is never asserted in IDLE.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro:
  - A counter increments each BUSY cycle with req_valid[g]=0. Cycles stalled only by tfifo_full do not count.
  - The counter clears on any transfer and on entry to BUSY.
  - When the count reaches TIMEOUT_CYCLES: next cycle state=IDLE, grant=0, rr pointer=(g+1) mod NREQ, and timeout_err=1 for exactly one cycle.
- Without the macro: no counter, the grant is held indefinitely, and timeout_err is tied to 0.

Decomposition:
- Shared package uart_arb_pkg holds:
  - the state enum (IDLE, BUSY);
  - the DW default;
  - the NREQ default.
- One combinational sub-module, rr_arb_pick.
  - Inputs: request vector and rr pointer.
  - Outputs: one-hot pick and an any-request flag.
  - It is reusable by other arbiters in the design.

Test Plan (NREQ=4):
- Reset then idle: hold rst_n=0 for 3 cycles with req_valid=4'b1111 → grant=0, tfifo_wr=0, req_ready=0 throughout. After release, grant=4'b0001 one cycle later.
- Round robin: all four requesters each send a 2-byte packet (0xA0|i, 0xB0|i), asserted simultaneously → FIFO receives A0 B0 A1 B1 A2 B2 A3 B3, with one idle cycle between packets.
- Non-interleave: req0 sends "HELLO" with valid gapped every other cycle while req2 is continuously valid → all 5 bytes of req0 are written before any req2 byte.
- Backpressure: tfifo_full=1 for 10 cycles mid-packet → req_ready[g]=0 and tfifo_wr=0 for those 10 cycles. The packet resumes with no byte lost or duplicated.
- Wrap and single-byte: the rr pointer is at 3 after a req2 packet, then req0 and req3 request single-byte packets → req3's byte is written first, then req0's byte, and the pointer ends at 1.
- Timeout (macro on, TIMEOUT_CYCLES=16): req1 sends 1 byte then drops valid without last → timeout_err pulses exactly once 16 idle cycles later. Grant then moves to the next pending requester.
